// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, XLEN iterations.
// Optional MULDIV_EARLY_OUT_EN: zero-operand ops skip CALC and complete one cycle after acceptance.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            stall_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]      r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_rs1;
  logic            r_neg;
  logic            r_rem_neg;
  logic            r_bzero;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_early;
  logic            w_last;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN:0]   w_msum;
  logic [XLEN:0]   w_dshift;
  logic [XLEN:0]   w_ddiff;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;

  function automatic logic a_signed(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b110: a_signed = 1'b1;
      default:                                a_signed = 1'b0;
    endcase
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b100, 3'b110: b_signed = 1'b1;
      default:                        b_signed = 1'b0;
    endcase
  endfunction

  // Sign correction and op-dependent selection of the final result.
  function automatic logic [XLEN-1:0] finish_op(
    input logic [2:0]      op,
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] lo,
    input logic            neg,
    input logic            rem_neg,
    input logic            bzero,
    input logic [XLEN-1:0] rs1
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = neg ? -{hi, lo} : {hi, lo};
    quo  = bzero ? '1  : (neg ? -lo : lo);
    rem  = bzero ? rs1 : (rem_neg ? -hi : hi);
    case (op)
      3'b000:                 finish_op = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: finish_op = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         finish_op = quo;
      default:                finish_op = rem;
    endcase
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  function automatic logic [XLEN-1:0] special_result(
    input logic [2:0]      op,
    input logic [XLEN-1:0] rs1,
    input logic [XLEN-1:0] rs2
  );
    if (!op[2])
      special_result = '0;
    else if (rs2 == '0)
      special_result = op[1] ? rs1 : '1;
    else
      special_result = '0;
  endfunction

  assign w_early = (rs1_i == '0) | (rs2_i == '0);
`else
  assign w_early = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) & start_i & ~flush_i;
  assign w_last   = (r_state == S_CALC) & (r_cnt == CW'(XLEN - 1));
  assign w_a_neg  = a_signed(op_i) & rs1_i[XLEN-1];
  assign w_b_neg  = b_signed(op_i) & rs2_i[XLEN-1];

  assign busy_o   = (r_state == S_CALC);
  assign done_o   = (r_state == S_DONE) & ~flush_i;
  assign result_o = r_result;
  assign stall_o  = start_i & ~done_o & ~flush_i;

  // One iteration: multiply adds B on the multiplier LSB and shifts right,
  // divide shifts the partial remainder left and restores on borrow.
  assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_dshift = {r_hi, r_lo[XLEN-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_b};

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_op[2]) begin
      if (!w_ddiff[XLEN]) begin
        w_hi_nxt = w_ddiff[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_dshift[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_msum[XLEN:1];
      w_lo_nxt = {w_msum[0], r_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_early ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (flush_i)     w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_rs1     <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_bzero   <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= op_i;
      r_hi      <= '0;
      r_lo      <= w_a_neg ? -rs1_i : rs1_i;
      r_b       <= w_b_neg ? -rs2_i : rs2_i;
      r_rs1     <= rs1_i;
      r_neg     <= w_a_neg ^ w_b_neg;
      r_rem_neg <= w_a_neg;
      r_bzero   <= (rs2_i == '0);
      r_cnt     <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      if (w_early) r_result <= special_result(op_i, rs1_i, rs2_i);
`endif
    end else if ((r_state == S_CALC) && !flush_i) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last)
        r_result <= finish_op(r_op, w_hi_nxt, w_lo_nxt, r_neg, r_rem_neg, r_bzero, r_rs1);
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide unit and sequencer for the RV32M ops (fun7 = 7'b0000001) of the core's execute stage.
- Accepts one op from execute, runs a shift-add multiply or restoring divide over XLEN cycles, and holds the pipeline through `stall_o` until the result is ready.
- Sits beside the single-cycle ALU. Execute steers M-extension R-type instructions here instead of to the ALU.

Parameters:
- XLEN, 32, operand/result width. Iteration count equals XLEN.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- start_i  in  1  M-op present in execute. Held high by the pipeline until done_o.
- op_i  in  3  fun3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  in  XLEN  operand A
- rs2_i  in  XLEN  operand B
- flush_i  in  1  pipeline flush/kill of the in-flight op
- busy_o  out  1  high in CALC state
- done_o  out  1  one-cycle pulse, result_o valid
- result_o  out  XLEN  registered result
- stall_o  out  1  combinational: start_i & ~done_o & ~flush_i

Behaviour:
- Reset state: FSM IDLE, busy_o=0, done_o=0, result_o=0. All internal accumulator, counter and sign flags are cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and flush_i=0 → latch op_i, rs1_i, rs2_i, go to CALC, counter=0.
  - Otherwise stay in IDLE.
- CALC:
  - One iteration per cycle, XLEN cycles total. Counter runs 0..XLEN-1.
  - On counter==XLEN-1: write the corrected result into result_o and go to DONE.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - start_i still high in this cycle is not re-accepted. Execute drops start_i once it sees done_o.
- Latency: start sampled at cycle 0, CALC occupies cycles 1..XLEN, done_o at cycle XLEN+1.
- Multiply:
  - Signed operands (per op) are converted to magnitude at latch; the unsigned 2*XLEN product is built by shift-add.
  - Sign fix on the final write: negate when the operand signs differ.
  - MULHSU treats rs2 as unsigned.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring, magnitudes as for multiply.
  - Quotient negated when the signs differ; remainder takes the dividend sign.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide by zero: quotient = all ones, remainder = rs1 (unmodified), for both signed and unsigned.
- Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- flush_i:
  - In CALC or DONE: next state IDLE, no done_o pulse, result_o unchanged.
  - In IDLE: blocks acceptance. flush_i and start_i in the same cycle → no op accepted.
- start_i changes while in CALC are ignored; the latched operands are used.
- result_o holds its value until the next successful completion.
- reset_n deasserted mid-op: immediate return to IDLE, all outputs at reset values.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- With the macro:
  - At acceptance, if rs2_i==0 (any op), or rs1_i==0 (any op), the FSM goes straight to DONE with the special or zero result.
  - done_o at cycle 1.
- Without the macro:
  - Every op takes the full XLEN+1 cycles; special results are applied on the final CALC cycle.
- Result values are identical in both builds; only latency differs.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) → done_o at cycle 33, result_o=0xFFFFFFEB. stall_o high cycles 0..32.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → result_o=0xFFFFFFFE. MULH same operands → 0x00000000.
- DIV rs1=-20, rs2=3 → 0xFFFFFFFA. REM same operands → 0xFFFFFFFE. DIVU 100/7 → 14, REMU → 2.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000. REM → 0. DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5. Done at cycle 1 with MULDIV_EARLY_OUT_EN, cycle 33 without.
- Start DIVU, flush_i at cycle 10 → IDLE at cycle 11, no done_o, result_o unchanged. A new MUL 2*3 started at cycle 12 → result_o=6 at cycle 45.
- Start MUL, drop reset_n at cycle 5 → busy_o=0, done_o=0, result_o=0 immediately. After release, start_i accepted normally.
